// File: rtl/intt_gs_scheduler_pkg.sv
// Shared types and helpers for the inverse-NTT (Gentleman-Sande) scheduler.
package ntt_pkg;

  localparam int unsigned DEFAULT_N = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } intt_state_e;

  // Butterfly span of stage s.
  function automatic int unsigned stage_len(input int unsigned s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/intt_gs_scheduler_if.sv
// Butterfly issue / write-back bus between the scheduler and the datapath pipeline.
interface intt_gs_scheduler_if #(
  parameter int LOGN = 8,
  parameter int SW   = $clog2(LOGN) + 1
);
  logic            bf_valid;
  logic            bf_ready;
  logic [LOGN-1:0] bf_addr_a;
  logic [LOGN-1:0] bf_addr_b;
  logic [LOGN-1:0] bf_tw_idx;
  logic [SW-1:0]   bf_stage;
  logic            wb_valid;

  modport master (
    output bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage,
    input  bf_ready, wb_valid
  );

  modport slave (
    input  bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage,
    output bf_ready, wb_valid
  );
endinterface

// File: rtl/intt_gs_scheduler_addr_gen.sv
// Registered stage/group/index walker producing butterfly operand addresses and
// the inverse-twiddle ROM index; the twiddle register doubles as the group counter.
module intt_addr_gen
  import ntt_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int LOGN = $clog2(N),
  parameter int SW   = $clog2(LOGN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            advance,
  input  logic            next_stage,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-1:0] tw_idx,
  output logic [SW-1:0]   stage,
  output logic            last_in_stage,
  output logic            last_stage
);

  localparam logic [LOGN-1:0] HALF_N   = LOGN'(N / 2);
  localparam logic [LOGN-1:0] MAX_ADDR = LOGN'(N - 1);
  localparam logic [SW-1:0]   LAST_S   = SW'(LOGN - 1);

  logic [LOGN-1:0] j_r;
  logic [LOGN-1:0] len_r;
  logic [LOGN-1:0] a_r;
  logic [LOGN-1:0] b_r;
  logic [LOGN-1:0] tw_r;
  logic [SW-1:0]   s_r;

  // Step j inside a group, hop to the next group at j==len-1; stage steps come from the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_r   <= {LOGN{1'b0}};
      len_r <= {LOGN{1'b0}};
      a_r   <= {LOGN{1'b0}};
      b_r   <= {LOGN{1'b0}};
      tw_r  <= {LOGN{1'b0}};
      s_r   <= {SW{1'b0}};
    end else if (load) begin
      j_r   <= {LOGN{1'b0}};
      len_r <= LOGN'(1);
      a_r   <= {LOGN{1'b0}};
      b_r   <= LOGN'(1);
      tw_r  <= HALF_N;
      s_r   <= {SW{1'b0}};
    end else if (next_stage) begin
      j_r   <= {LOGN{1'b0}};
      len_r <= LOGN'(stage_len(32'(s_r) + 32'd1));
      a_r   <= {LOGN{1'b0}};
      b_r   <= LOGN'(stage_len(32'(s_r) + 32'd1));
      tw_r  <= HALF_N >> (s_r + SW'(1));
      s_r   <= s_r + SW'(1);
    end else if (advance && !last_in_stage) begin
      if (j_r == len_r - LOGN'(1)) begin
        j_r  <= {LOGN{1'b0}};
        a_r  <= a_r + len_r + LOGN'(1);
        b_r  <= b_r + len_r + LOGN'(1);
        tw_r <= tw_r + LOGN'(1);
      end else begin
        j_r <= j_r + LOGN'(1);
        a_r <= a_r + LOGN'(1);
        b_r <= b_r + LOGN'(1);
      end
    end
  end

  // Only the final butterfly of a stage touches the top address.
  assign last_in_stage = (b_r == MAX_ADDR);
  assign last_stage    = (s_r == LAST_S);
  assign addr_a        = a_r;
  assign addr_b        = b_r;
  assign tw_idx        = tw_r;
  assign stage         = s_r;

endmodule

// File: rtl/intt_gs_scheduler_chk.sv
// Protocol checks on the outstanding write-back counter.
module intt_gs_scheduler_chk #(
  parameter int OW           = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input logic          clk,
  input logic          rst_n,
  input logic          wb_valid,
  input logic          issue,
  input logic [OW-1:0] outs
);
  localparam logic [OW-1:0] MAX_C = OW'(MAX_INFLIGHT);

  a_wb_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    wb_valid |-> (outs != {OW{1'b0}}));

  a_inflight_cap: assert property (@(posedge clk) disable iff (!rst_n)
    issue |-> (outs < MAX_C));
endmodule

// File: rtl/intt_gs_scheduler.sv
// Inverse-NTT butterfly scheduler: issues every Gentleman-Sande butterfly and
// fences each stage until all of its write-backs have returned.
module intt_gs_scheduler
  import ntt_pkg::*;
#(
  parameter int N            = DEFAULT_N,
  parameter int LOGN         = $clog2(N),
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  intt_gs_scheduler_if.master bf
);

  localparam int SW = $clog2(LOGN) + 1;
  localparam int OW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [OW-1:0] MAX_C = OW'(MAX_INFLIGHT);

  intt_state_e     state_r;
  intt_state_e     state_s;
  logic [OW-1:0]   outs_r;
  logic [OW-1:0]   outs_s;
  logic            busy_r;
  logic            done_r;
  logic            valid_r;
  logic            hs_s;
  logic            load_s;
  logic            adv_s;
  logic            nxt_s;
  logic            last_in_stage_s;
  logic            last_stage_s;
  logic [LOGN-1:0] addr_a_s;
  logic [LOGN-1:0] addr_b_s;
  logic [LOGN-1:0] tw_s;
  logic [SW-1:0]   stage_s;

  assign hs_s = valid_r && bf.bf_ready;

  intt_addr_gen #(.N(N), .LOGN(LOGN), .SW(SW)) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_s),
    .advance      (adv_s),
    .next_stage   (nxt_s),
    .addr_a       (addr_a_s),
    .addr_b       (addr_b_s),
    .tw_idx       (tw_s),
    .stage        (stage_s),
    .last_in_stage(last_in_stage_s),
    .last_stage   (last_stage_s)
  );

  // Outstanding count; a stray write-back at zero saturates instead of wrapping.
  always_comb begin
    outs_s = outs_r;
    if (hs_s && !bf.wb_valid) begin
      outs_s = outs_r + OW'(1);
    end else if (!hs_s && bf.wb_valid && (outs_r != {OW{1'b0}})) begin
      outs_s = outs_r - OW'(1);
    end else begin
      outs_s = outs_r;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ISSUE;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (hs_s) begin
          adv_s   = 1'b1;
          state_s = last_in_stage_s ? DRAIN : ISSUE;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (outs_s == {OW{1'b0}}) begin
          if (last_stage_s) begin
            state_s = DONE;
          end else begin
            state_s = ISSUE;
            nxt_s   = 1'b1;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counter and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      outs_r  <= {OW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      outs_r  <= outs_s;
      busy_r  <= (state_s == ISSUE) || (state_s == DRAIN);
      done_r  <= (state_s == DONE);
      valid_r <= (state_s == ISSUE) && (outs_s < MAX_C);
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign bf.bf_valid  = valid_r;
  assign bf.bf_addr_a = addr_a_s;
  assign bf.bf_addr_b = addr_b_s;
  assign bf.bf_tw_idx = tw_s;
  assign bf.bf_stage  = stage_s;

  intt_gs_scheduler_chk #(.OW(OW), .MAX_INFLIGHT(MAX_INFLIGHT)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_valid(bf.wb_valid),
    .issue   (valid_r),
    .outs    (outs_r)
  );

endmodule

// File: tb/tb_intt_gs_scheduler.sv
// Directed bench: N=8 instance with hand-computed issue tables, and an N=256,
// MAX_INFLIGHT=2 instance under random ready against a golden loop model.
module tb_intt_gs_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, busy_a, done_a;
  logic start_b, busy_b, done_b;

  intt_gs_scheduler_if #(.LOGN(3)) ifa ();
  intt_gs_scheduler_if #(.LOGN(8)) ifb ();

  intt_gs_scheduler #(.N(8), .LOGN(3), .MAX_INFLIGHT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .bf(ifa.master)
  );

  intt_gs_scheduler #(.N(256), .LOGN(8), .MAX_INFLIGHT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .bf(ifb.master)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hand-computed N=8 issue order: addr_a, addr_b, twiddle; stage = index/4.
  int tab_a[12];
  int tab_b[12];
  int tab_t[12];
  int ga[1024];
  int gb[1024];
  int gt[1024];
  int gs[1024];

  int   cyc = 0;
  int   q_a[$];
  int   q_b[$];
  bit   hold_a = 1'b0;
  int   wb_cnt_a = 0;
  int   idx_a = 0;
  int   idx_b = 0;
  int   outs_m = 0;
  bit   b_on = 1'b0;
  bit   hs_b, wb_b, ev_b;
  bit   pv_b = 1'b0;
  bit   pr_b = 1'b0;
  logic [27:0] pf_b;

  // Monitors and write-back responders for both instances, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      ifa.wb_valid = 1'b0;
      ifb.wb_valid = 1'b0;
      pv_b = 1'b0;
    end else begin
      if (ifa.bf_valid && ifa.bf_ready) begin
        if (idx_a < 12) begin
          check("a_addr_a", ifa.bf_addr_a, tab_a[idx_a]);
          check("a_addr_b", ifa.bf_addr_b, tab_b[idx_a]);
          check("a_tw_idx", ifa.bf_tw_idx, tab_t[idx_a]);
          check("a_stage", ifa.bf_stage, idx_a / 4);
        end
        idx_a++;
        q_a.push_back(cyc + 3);
      end
      if (q_a.size() > 0 && q_a[0] <= cyc && !hold_a) begin
        ifa.wb_valid = 1'b1;
        void'(q_a.pop_front());
        wb_cnt_a++;
      end else begin
        ifa.wb_valid = 1'b0;
      end

      if (b_on) begin
        if (pv_b && !pr_b) begin
          check("b_stall_valid", ifb.bf_valid, 1);
          check("b_stall_fields", {ifb.bf_stage, ifb.bf_tw_idx, ifb.bf_addr_a, ifb.bf_addr_b}, pf_b);
        end
        if (idx_b >= 1024) ev_b = 1'b0;
        else if (idx_b % 128 == 0) ev_b = (outs_m == 0);
        else ev_b = (outs_m < 2);
        if (idx_b > 0) check("b_valid_gate", ifb.bf_valid, ev_b);
        hs_b = ifb.bf_valid && ifb.bf_ready;
        if (hs_b) begin
          if (idx_b < 1024)
            check("b_issue", {ifb.bf_stage, ifb.bf_tw_idx, ifb.bf_addr_a, ifb.bf_addr_b},
                  (gs[idx_b] << 24) | (gt[idx_b] << 16) | (ga[idx_b] << 8) | gb[idx_b]);
          idx_b++;
          q_b.push_back(cyc + 10);
        end
        wb_b = (q_b.size() > 0) && (q_b[0] <= cyc);
        if (wb_b) void'(q_b.pop_front());
        ifb.wb_valid = wb_b;
        outs_m = outs_m + int'(hs_b) - int'(wb_b);
        pv_b = ifb.bf_valid;
        pr_b = ifb.bf_ready;
        pf_b = {ifb.bf_stage, ifb.bf_tw_idx, ifb.bf_addr_a, ifb.bf_addr_b};
      end else begin
        ifb.wb_valid = 1'b0;
      end
    end
  end

  task automatic wait_done_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idx_a(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (idx_a >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic start_run_a();
    idx_a   = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    bit ok;
    bit early;
    int base;
    int k;

    tab_a = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    tab_b = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    tab_t = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};
    k = 0;
    for (int s = 0; s < 8; s++)
      for (int g = 0; g < 256 / (2 << s); g++)
        for (int j = 0; j < (1 << s); j++) begin
          ga[k] = g * 2 * (1 << s) + j;
          gb[k] = ga[k] + (1 << s);
          gt[k] = (256 >> (s + 1)) + g;
          gs[k] = s;
          k++;
        end

    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ifa.bf_ready = 1'b1;
    ifb.bf_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_valid", ifa.bf_valid, 0);
    check("rst_fields", {ifa.bf_stage, ifa.bf_tw_idx, ifa.bf_addr_a, ifa.bf_addr_b}, 0);
    rst_n = 1'b1;
    tick();

    // Run 1: first issue one cycle after start, then full sequence and done timing.
    start_run_a();
    check("a_first_valid", ifa.bf_valid, 1);
    check("a_first_busy", busy_a, 1);
    wait_done_a(ok);
    check("a_done_seen", ok, 1);
    check("a_done_busy", busy_a, 0);
    check("a_hs_count", idx_a, 12);
    tick();
    check("a_done_pulse", done_a, 0);
    check("a_idle_busy", busy_a, 0);
    start_run_a();
    check("a_restart_busy", busy_a, 1);
    check("a_restart_valid", ifa.bf_valid, 1);

    // Run 2: start pulsed while busy must not restart.
    repeat (3) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(ok);
    check("a_busy_start_done", ok, 1);
    check("a_busy_start_count", idx_a, 12);

    // Run 3: write-backs withheld at the end of stage 0.
    tick();
    hold_a = 1'b1;
    start_run_a();
    wait_idx_a(4, ok);
    check("a_stage0_issued", ok, 1);
    repeat (5) tick();
    check("a_drain_valid", ifa.bf_valid, 0);
    check("a_drain_stage", ifa.bf_stage, 0);
    base = wb_cnt_a;
    hold_a = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wb_cnt_a - base >= 4) break;
      if (ifa.bf_valid) early = 1'b1;
    end
    check("a_drain_gate", early, 0);
    check("a_s1_valid", ifa.bf_valid, 1);
    check("a_s1_fields", {ifa.bf_stage, ifa.bf_tw_idx, ifa.bf_addr_a, ifa.bf_addr_b}, {3'd1, 3'd2, 3'd0, 3'd2});
    wait_done_a(ok);
    check("a_hold_done", ok, 1);
    check("a_hold_count", idx_a, 12);

    // Run 4: asynchronous reset in stage 1, then a clean replay.
    tick();
    start_run_a();
    wait_idx_a(5, ok);
    check("a_reach_s1", ifa.bf_stage, 1);
    rst_n = 1'b0;
    #1;
    check("a_arst_busy", busy_a, 0);
    check("a_arst_valid", ifa.bf_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_run_a();
    check("a_replay_valid", ifa.bf_valid, 1);
    check("a_replay_fields", {ifa.bf_stage, ifa.bf_tw_idx, ifa.bf_addr_a, ifa.bf_addr_b}, {3'd0, 3'd4, 3'd0, 3'd1});
    wait_done_a(ok);
    check("a_replay_done", ok, 1);
    check("a_replay_count", idx_a, 12);

    // N=256, two in flight, ten-cycle write-back latency, random ready.
    tick();
    idx_b = 0;
    outs_m = 0;
    b_on = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      ifb.bf_ready = 1'($urandom_range(0, 1));
      tick();
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
    check("b_done_seen", ok, 1);
    check("b_done_busy", busy_b, 0);
    check("b_hs_count", idx_b, 1024);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/intt_gs_scheduler.md
Name: intt_gs_scheduler

Overview:
Sequences one full N-point inverse NTT over an external coefficient RAM using the Gentleman-Sande butterfly datapath (a' = a+b, b' = (a−b)·ψ^(−k)). For every butterfly it issues the operand addresses and the inverse-twiddle ROM index. At each stage boundary it stalls until all write-backs from that stage have returned, so the next stage never reads stale data. It sits between the top-level NTT core control and the read/butterfly/write-back pipeline.

Parameters:
N, 256, transform length; power of two, 4..1024
LOGN, $clog2(N), number of stages and address width
MAX_INFLIGHT, 8, max butterflies issued but not yet written back; sizes the outstanding counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a transform; ignored unless IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the final stage is fully written back
bf_valid  output  1  butterfly issue valid
bf_ready  input  1  pipeline accepts an issue when bf_valid && bf_ready
bf_addr_a  output  LOGN  address of operand a
bf_addr_b  output  LOGN  address of operand b (bf_addr_a + len)
bf_tw_idx  output  LOGN  inverse-twiddle ROM index
bf_stage  output  $clog2(LOGN)+1  current stage s, 0..LOGN-1
wb_valid  input  1  one pulse per completed butterfly write-back (both words)

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, bf_valid=0; all counters, addresses, bf_stage and bf_tw_idx = 0.
- Loop order: stage s = 0..LOGN-1, len = 1<<s; group g = 0..N/(2·len)−1; j = 0..len−1.
  - addr_a = g·2·len + j; addr_b = addr_a + len.
  - tw_idx = (N>>(s+1)) + g. The ROM holds ψ^(−k) in per-stage bit-reversed order at indices 1..N−1.
- Each stage issues N/2 butterflies; a run issues LOGN·N/2 in total.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 → ISSUE next cycle; counters are cleared and busy rises.
  - ISSUE: bf_valid=1 while outstanding < MAX_INFLIGHT; otherwise bf_valid=0.
    - Issue counters (j, g) advance only on the bf_valid && bf_ready handshake.
    - Issue fields hold stable while valid && !ready.
    - After the last butterfly of a stage is accepted → DRAIN.
  - DRAIN: bf_valid=0; wait for outstanding==0.
    - Not the last stage: s+1, j=0, g=0 → ISSUE.
    - Last stage → DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in the same cycle → IDLE.
- Outstanding counter: +1 on handshake, −1 on wb_valid, unchanged when both occur in the same cycle.
  - wb_valid while outstanding==0 is a protocol error: counter saturates at 0; the verification assertion fires.
- Issue latency: the first bf_valid appears 1 cycle after start is sampled. Outputs are registered; no combinational path from bf_ready to bf_valid.
- start during busy: ignored, with no effect on counters.
- Async reset mid-run: immediate return to IDLE. In-flight write-backs arriving after reset are ignored (counter held at 0).
- The block does not perform the final N^−1 scaling pass.

Decomposition:
- Shared package ntt_pkg holds:
  - typedef intt_state_e {IDLE, ISSUE, DRAIN, DONE}
  - function stage_len(s)
  - constant DEFAULT_N
- One sub-module, intt_addr_gen: registered j/g/s counters producing addr_a, addr_b and tw_idx, plus last_in_stage and last_stage flags. Advances on an enable, clears on a load.
- Top level holds the FSM and the outstanding counter.

Test Plan:
- N=8, bf_ready=1, wb_valid looped back 3 cycles after each handshake:
  - stage 0 issues (0,1,tw4),(2,3,tw5),(4,5,tw6),(6,7,tw7)
  - stage 1 issues (0,2,tw2),(1,3,tw2),(4,6,tw3),(5,7,tw3)
  - stage 2 issues (0,4,tw1),(1,5,tw1),(2,6,tw1),(3,7,tw1)
  - 12 handshakes total, then a single done pulse.
- Random bf_ready toggling, N=256 → exactly 1024 handshakes. Issue fields stay stable across every stalled cycle, and the sequence matches the golden loop model.
- wb_valid withheld at the end of stage 0 (N=8) → bf_valid stays 0 with bf_stage=0 until the 4th wb_valid; the stage-1 first issue follows 1 cycle later.
- MAX_INFLIGHT=2, write-backs delayed 10 cycles → bf_valid drops after 2 outstanding and reasserts the cycle after a wb_valid. Same-cycle issue+wb leaves the count unchanged.
- start pulsed while busy → no restart, and the total handshake count is unchanged. rst_n low mid-stage-1 → busy=0, bf_valid=0 immediately. A new start then replays from (0,1,tw4).
- done timing: done high for exactly 1 cycle, busy low in the same cycle, and start accepted in the following cycle.
